// File: rtl/usbfs_txn_ctrl.sv
// usbfs_txn_ctrl -- USB full-speed device transaction controller.
//
// Sequences token / data / handshake phases for a device with N_ENDP
// endpoints. Tokens addressed to this device start OUT/SETUP receive or
// IN transmit phases; SOF tokens report the frame number. Per-endpoint
// DATA0/DATA1 toggles are tracked separately for the OUT and IN directions.
//
// Ports
//   i_clk_48MHz        sole clock
//   i_rst              asynchronous active-high reset
//   i_strobe_12MHz     bit strobe from the receiver, paces the timeout
//   i_eop              one-cycle end-of-packet pulse; receiver results valid
//   i_pid .. i_lastData_nBytes  receiver results for the finished packet
//   i_devAddr          assigned device address
//   i_outReady         per-endpoint: OUT sink can take a payload
//   i_inValid          per-endpoint: IN source holds a payload
//   o_txReq/o_txPid    transmit request and PID to send; i_txDone ends it
//   o_outCommit        pulse: OUT/SETUP payload accepted (o_outSetup, o_outNBytes)
//   o_inCommit         pulse: host ACKed the IN payload
//   o_endp             endpoint of current/last transaction
//   o_sof/o_frameNumber pulse on SOF and the frame number carried by it
module usbfs_txn_ctrl #(
  parameter int N_ENDP  = 4,
  parameter int MAX_PKT = 8,
  localparam int NB_W   = $clog2(MAX_PKT) + 1
) (
  input  logic              i_clk_48MHz,
  input  logic              i_rst,
  input  logic              i_strobe_12MHz,
  input  logic              i_eop,
  input  logic [3:0]        i_pid,
  input  logic              i_pidOkay,
  input  logic              i_tokenOkay,
  input  logic              i_dataOkay,
  input  logic [6:0]        i_lastAddr,
  input  logic [3:0]        i_lastEndp,
  input  logic [NB_W-1:0]   i_lastData_nBytes,
  input  logic [6:0]        i_devAddr,
  input  logic [N_ENDP-1:0] i_outReady,
  input  logic [N_ENDP-1:0] i_inValid,
  output logic              o_txReq,
  output logic [3:0]        o_txPid,
  input  logic              i_txDone,
  output logic              o_outCommit,
  output logic              o_outSetup,
  output logic [NB_W-1:0]   o_outNBytes,
  output logic              o_inCommit,
  output logic [3:0]        o_endp,
  output logic              o_sof,
  output logic [10:0]       o_frameNumber
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [4:0] ENDP_LIM  = 5'(N_ENDP);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_DATA  = 3'd1,
    TX_HS    = 3'd2,
    TX_DATA  = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  state_t      state;
  logic [4:0]  tmo_cnt;
  logic        is_setup;
  // Toggles kept 16 wide so a 4-bit endpoint indexes them directly; only
  // the low N_ENDP bits are ever written.
  logic [15:0] out_toggle;
  logic [15:0] in_toggle;

  logic [15:0] out_ready_x;
  logic [15:0] in_valid_x;
  logic        token_ok;
  logic        token_match;
  logic        data_ok;

  // Decode of the receiver results for the current cycle.
  always_comb begin
    out_ready_x = 16'(i_outReady);
    in_valid_x  = 16'(i_inValid);
    token_ok    = i_eop && i_pidOkay && i_tokenOkay && (i_pid[1:0] == 2'b01);
    token_match = (i_lastAddr == i_devAddr) && ({1'b0, i_lastEndp} < ENDP_LIM);
    data_ok     = i_pidOkay && i_dataOkay && (i_pid[1:0] == 2'b11);
  end

  // Transaction FSM with registered outputs, toggles and timeout counter.
  always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      tmo_cnt       <= 5'd0;
      is_setup      <= 1'b0;
      out_toggle    <= 16'd0;
      in_toggle     <= 16'd0;
      o_txReq       <= 1'b0;
      o_txPid       <= 4'b0000;
      o_outCommit   <= 1'b0;
      o_outSetup    <= 1'b0;
      o_outNBytes   <= '0;
      o_inCommit    <= 1'b0;
      o_endp        <= 4'd0;
      o_sof         <= 1'b0;
      o_frameNumber <= 11'd0;
    end else begin
      // Pulse outputs default low so each lasts exactly one cycle.
      o_sof       <= 1'b0;
      o_outCommit <= 1'b0;
      o_inCommit  <= 1'b0;

      case (state)
        IDLE: begin
          if (token_ok) begin
            if (i_pid == PID_SOF) begin
              // SOF is a broadcast: no address or endpoint check.
              o_sof         <= 1'b1;
              o_frameNumber <= {i_lastEndp, i_lastAddr};
            end else if (token_match) begin
              if ((i_pid == PID_OUT) || (i_pid == PID_SETUP)) begin
                o_endp   <= i_lastEndp;
                is_setup <= (i_pid == PID_SETUP);
                tmo_cnt  <= 5'd0;
                state    <= RX_DATA;
              end else if (i_pid == PID_IN) begin
                o_endp  <= i_lastEndp;
                o_txReq <= 1'b1;
                if (in_valid_x[i_lastEndp]) begin
                  o_txPid <= in_toggle[i_lastEndp] ? PID_DATA1 : PID_DATA0;
                  state   <= TX_DATA;
                end else begin
                  o_txPid <= PID_NAK;
                  state   <= TX_HS;
                end
              end
            end
          end
        end

        RX_DATA: begin
          if (i_eop) begin
            if (data_ok) begin
              o_txReq <= 1'b1;
              state   <= TX_HS;
              if (is_setup) begin
                // SETUP is always accepted and resets both directions to DATA1.
                o_txPid            <= PID_ACK;
                o_outCommit        <= 1'b1;
                o_outSetup         <= 1'b1;
                o_outNBytes        <= i_lastData_nBytes;
                out_toggle[o_endp] <= 1'b1;
                in_toggle[o_endp]  <= 1'b1;
              end else if (!out_ready_x[o_endp]) begin
                o_txPid <= PID_NAK;
              end else if (i_pid[3] == out_toggle[o_endp]) begin
                o_txPid            <= PID_ACK;
                o_outCommit        <= 1'b1;
                o_outSetup         <= 1'b0;
                o_outNBytes        <= i_lastData_nBytes;
                out_toggle[o_endp] <= ~out_toggle[o_endp];
              end else begin
                // Toggle mismatch: host retransmitted after a lost ACK.
                o_txPid <= PID_ACK;
              end
            end else begin
              state <= IDLE;
            end
          end else if (i_strobe_12MHz) begin
            if (tmo_cnt == 5'd31) begin
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 5'd1;
            end
          end
        end

        TX_HS: begin
          if (i_txDone) begin
            o_txReq <= 1'b0;
            state   <= IDLE;
          end
        end

        TX_DATA: begin
          if (i_txDone) begin
            o_txReq <= 1'b0;
            tmo_cnt <= 5'd0;
            state   <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (i_eop) begin
            if ((i_pid == PID_ACK) && i_pidOkay) begin
              o_inCommit        <= 1'b1;
              in_toggle[o_endp] <= ~in_toggle[o_endp];
            end
            state <= IDLE;
          end else if (i_strobe_12MHz) begin
            if (tmo_cnt == 5'd31) begin
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 5'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbfs_txn_ctrl.sv
// Directed testbench for usbfs_txn_ctrl (N_ENDP=4, MAX_PKT=8, NB_W=4).
module tb_usbfs_txn_ctrl;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [6:0] DEV       = 7'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic        eop;
  logic [3:0]  pid;
  logic        pid_ok, tok_ok, dat_ok;
  logic [6:0]  last_addr;
  logic [3:0]  last_endp;
  logic [3:0]  last_nb;
  logic [6:0]  dev_addr;
  logic [3:0]  out_ready;
  logic [3:0]  in_valid;
  logic        tx_req;
  logic [3:0]  tx_pid;
  logic        tx_done;
  logic        out_commit, out_setup, in_commit, sof;
  logic [3:0]  out_nbytes;
  logic [3:0]  endp;
  logic [10:0] frame;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  usbfs_txn_ctrl #(.N_ENDP(4), .MAX_PKT(8)) dut (
    .i_clk_48MHz      (clk),
    .i_rst            (rst),
    .i_strobe_12MHz   (strobe),
    .i_eop            (eop),
    .i_pid            (pid),
    .i_pidOkay        (pid_ok),
    .i_tokenOkay      (tok_ok),
    .i_dataOkay       (dat_ok),
    .i_lastAddr       (last_addr),
    .i_lastEndp       (last_endp),
    .i_lastData_nBytes(last_nb),
    .i_devAddr        (dev_addr),
    .i_outReady       (out_ready),
    .i_inValid        (in_valid),
    .o_txReq          (tx_req),
    .o_txPid          (tx_pid),
    .i_txDone         (tx_done),
    .o_outCommit      (out_commit),
    .o_outSetup       (out_setup),
    .o_outNBytes      (out_nbytes),
    .o_inCommit       (in_commit),
    .o_endp           (endp),
    .o_sof            (sof),
    .o_frameNumber    (frame)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One packet end: fields valid with a single-cycle eop; returns on the
  // falling edge after the clock edge that consumed it.
  task automatic put_eop(input logic [3:0] p, input logic tk, input logic dk,
                         input logic [6:0] a, input logic [3:0] e, input logic [3:0] nb);
    @(negedge clk);
    pid = p; pid_ok = 1'b1; tok_ok = tk; dat_ok = dk;
    last_addr = a; last_endp = e; last_nb = nb; eop = 1'b1;
    @(negedge clk);
    eop = 1'b0; pid_ok = 1'b0; tok_ok = 1'b0; dat_ok = 1'b0;
  endtask

  task automatic token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    put_eop(p, 1'b1, 1'b0, a, e, 4'd0);
  endtask

  task automatic data(input logic [3:0] p, input logic ok, input logic [3:0] nb);
    put_eop(p, 1'b0, ok, 7'd0, 4'd0, nb);
  endtask

  // Hold the transmitter busy a few cycles, then finish it.
  task automatic finish_tx(input string tag, input logic [3:0] exp_pid);
    repeat (3) @(negedge clk);
    check_eq({tag, "_req_hold"}, 32'(tx_req), 32'd1);
    check_eq({tag, "_pid_hold"}, 32'(tx_pid), 32'(exp_pid));
    tx_done = 1'b1;
    check_eq({tag, "_req_done"}, 32'(tx_req), 32'd1);
    @(negedge clk);
    tx_done = 1'b0;
    check_eq({tag, "_req_drop"}, 32'(tx_req), 32'd0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); strobe = 1'b1;
      @(negedge clk); strobe = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; eop = 1'b0; pid = 4'd0;
    pid_ok = 1'b0; tok_ok = 1'b0; dat_ok = 1'b0;
    last_addr = 7'd0; last_endp = 4'd0; last_nb = 4'd0;
    dev_addr = DEV; out_ready = 4'b1111; in_valid = 4'b0000; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txreq", 32'(tx_req), 32'd0);
    check_eq("rst_txpid", 32'(tx_pid), 32'd0);
    check_eq("rst_frame", 32'(frame), 32'd0);
    check_eq("rst_endp", 32'(endp), 32'd0);
    check_eq("rst_pulses", {29'd0, sof, out_commit, in_commit}, 32'd0);
    rst = 1'b0;

    // SETUP to endpoint 0, DATA0, 8 bytes.
    token(PID_SETUP, DEV, 4'd0);
    check_eq("setup_tok_noreq", 32'(tx_req), 32'd0);
    data(PID_DATA0, 1'b1, 4'd8);
    check_eq("setup_req", 32'(tx_req), 32'd1);
    check_eq("setup_ack", 32'(tx_pid), 32'(PID_ACK));
    check_eq("setup_commit", 32'(out_commit), 32'd1);
    check_eq("setup_flag", 32'(out_setup), 32'd1);
    check_eq("setup_nbytes", 32'(out_nbytes), 32'd8);
    @(negedge clk);
    check_eq("setup_commit_pulse", 32'(out_commit), 32'd0);
    finish_tx("setup", PID_ACK);

    // IN endpoint 0 after SETUP: DATA1, host ACK commits.
    in_valid = 4'b0001;
    token(PID_IN, DEV, 4'd0);
    check_eq("in1_pid", 32'(tx_pid), 32'(PID_DATA1));
    finish_tx("in1", PID_DATA1);
    put_eop(PID_ACK, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0);
    check_eq("in1_commit", 32'(in_commit), 32'd1);
    @(negedge clk);
    check_eq("in1_commit_pulse", 32'(in_commit), 32'd0);

    // Nothing to send: NAK.
    in_valid = 4'b0000;
    token(PID_IN, DEV, 4'd0);
    check_eq("in_nak", 32'(tx_pid), 32'(PID_NAK));
    finish_tx("in_nak", PID_NAK);

    // Toggle flipped: DATA0; host replies NAK-like packet -> no commit.
    in_valid = 4'b0001;
    token(PID_IN, DEV, 4'd0);
    check_eq("in2_pid", 32'(tx_pid), 32'(PID_DATA0));
    finish_tx("in2", PID_DATA0);
    put_eop(PID_NAK, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0);
    check_eq("in2_nocommit", 32'(in_commit), 32'd0);
    token(PID_IN, DEV, 4'd0);
    check_eq("in3_pid_retry", 32'(tx_pid), 32'(PID_DATA0));
    finish_tx("in3", PID_DATA0);
    put_eop(PID_ACK, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0);
    check_eq("in3_commit", 32'(in_commit), 32'd1);

    // OUT endpoint 1: DATA0 accepted, duplicate DATA0 ACKed only, DATA1 accepted.
    token(PID_OUT, DEV, 4'd1);
    check_eq("out_endp", 32'(endp), 32'd1);
    data(PID_DATA0, 1'b1, 4'd3);
    check_eq("out1_ack", 32'(tx_pid), 32'(PID_ACK));
    check_eq("out1_commit", 32'(out_commit), 32'd1);
    check_eq("out1_setup", 32'(out_setup), 32'd0);
    check_eq("out1_nbytes", 32'(out_nbytes), 32'd3);
    finish_tx("out1", PID_ACK);
    token(PID_OUT, DEV, 4'd1);
    data(PID_DATA0, 1'b1, 4'd5);
    check_eq("out_dup_ack", 32'(tx_pid), 32'(PID_ACK));
    check_eq("out_dup_nocommit", 32'(out_commit), 32'd0);
    finish_tx("out_dup", PID_ACK);
    token(PID_OUT, DEV, 4'd1);
    data(PID_DATA1, 1'b1, 4'd0);
    check_eq("out2_commit", 32'(out_commit), 32'd1);
    check_eq("out2_nbytes", 32'(out_nbytes), 32'd0);
    finish_tx("out2", PID_ACK);

    // Sink not ready: NAK, no commit.
    out_ready = 4'b1011;
    token(PID_OUT, DEV, 4'd2);
    data(PID_DATA0, 1'b1, 4'd4);
    check_eq("out_nak_pid", 32'(tx_pid), 32'(PID_NAK));
    check_eq("out_nak_nocommit", 32'(out_commit), 32'd0);
    finish_tx("out_nak", PID_NAK);
    out_ready = 4'b1111;

    // 31 strobes is still inside the window; endp1 toggle is back to 0.
    token(PID_OUT, DEV, 4'd1);
    strobes(31);
    data(PID_DATA0, 1'b1, 4'd6);
    check_eq("tmo31_commit", 32'(out_commit), 32'd1);
    finish_tx("tmo31", PID_ACK);
    // 32 strobes times out; late data is ignored.
    token(PID_OUT, DEV, 4'd1);
    strobes(32);
    check_eq("tmo32_noreq", 32'(tx_req), 32'd0);
    data(PID_DATA1, 1'b1, 4'd2);
    check_eq("tmo32_late_noreq", 32'(tx_req), 32'd0);
    check_eq("tmo32_late_nocommit", 32'(out_commit), 32'd0);
    token(PID_OUT, DEV, 4'd1);
    data(PID_DATA1, 1'b1, 4'd2);
    check_eq("after_tmo_commit", 32'(out_commit), 32'd1);
    finish_tx("after_tmo", PID_ACK);

    // Bad data CRC: no handshake, back to idle.
    token(PID_OUT, DEV, 4'd1);
    data(PID_DATA0, 1'b0, 4'd1);
    check_eq("baddata_noreq", 32'(tx_req), 32'd0);
    check_eq("baddata_nocommit", 32'(out_commit), 32'd0);
    // Wrong address and out-of-range endpoint are ignored.
    token(PID_OUT, 7'h16, 4'd1);
    data(PID_DATA0, 1'b1, 4'd1);
    check_eq("wrongaddr_noreq", 32'(tx_req), 32'd0);
    token(PID_IN, DEV, 4'd4);
    check_eq("badendp_noreq", 32'(tx_req), 32'd0);

    // SOF frame 0x5A3 = {4'hB, 7'h23}.
    token(PID_SOF, 7'h23, 4'hB);
    check_eq("sof_pulse", 32'(sof), 32'd1);
    check_eq("sof_frame", 32'(frame), 32'h5A3);
    @(negedge clk);
    check_eq("sof_pulse_end", 32'(sof), 32'd0);

    // Reset in the middle of a DATA1 transmit.
    token(PID_SETUP, DEV, 4'd0);
    data(PID_DATA0, 1'b1, 4'd1);
    finish_tx("setup2", PID_ACK);
    token(PID_IN, DEV, 4'd0);
    check_eq("pre_rst_pid", 32'(tx_pid), 32'(PID_DATA1));
    #3 rst = 1'b1;
    #1;
    check_eq("rst_async_txreq", 32'(tx_req), 32'd0);
    check_eq("rst_async_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    token(PID_IN, DEV, 4'd0);
    check_eq("post_rst_pid", 32'(tx_pid), 32'(PID_DATA0));
    finish_tx("post_rst", PID_DATA0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
